// File: rtl/jtag_ram_arbiter_pkg.sv
// Shared types for the debug block RAM arbiter: width defaults, lock-FSM states,
// and the pipeline tag that follows each access to its read response.
package jtag_ram_pkg;

  localparam int unsigned DefAw = 9;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StFree,
    StOwnA,
    StOwnB
  } arb_state_e;

  // port: 0 = requester A, 1 = requester B
  typedef struct packed {
    logic port;
    logic is_read;
  } tag_t;

endpackage

// File: rtl/jtag_ram_arbiter_if.sv
// Requester A/B request/response channels plus the single RAM port.
// Lock inputs exist only when ARB_LOCK_EN is defined.
interface jtag_ram_arbiter_if
  import jtag_ram_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) ();

  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic          a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
`ifdef ARB_LOCK_EN
  logic          a_lock, b_lock;
`endif
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  // Arbiter side
  modport slave (
`ifdef ARB_LOCK_EN
    input  a_lock, b_lock,
`endif
    input  a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_do,
    output a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output ram_en, ram_we, ram_addr, ram_di
  );

  // Requesters and RAM side
  modport master (
`ifdef ARB_LOCK_EN
    output a_lock, b_lock,
`endif
    output a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_do,
    input  a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  ram_en, ram_we, ram_addr, ram_di
  );

endinterface

// File: rtl/jtag_ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; last_gnt_i = 1 means B was granted last.
module rr_arb2 (
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic last_gnt_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  always_comb begin
    gnt_a_o = a_req_i && (!b_req_i || last_gnt_i);
    gnt_b_o = b_req_i && (!a_req_i || !last_gnt_i);
  end

endmodule

// File: rtl/jtag_ram_arbiter.sv
// Two-requester arbiter/sequencer for one debug block RAM port: grant, stage-1 RAM drive,
// stage-2 read routing. Define ARB_LOCK_EN to enable bounded-burst ownership locking.
module jtag_ram_arbiter
  import jtag_ram_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
`ifdef ARB_LOCK_EN
  ,
  parameter int unsigned MAX_LOCK = 16
`endif
) (
  input logic              clk_p,
  input logic              rst_top,
  jtag_ram_arbiter_if.slave bus
);

  logic          rr_a, rr_b;
  logic          gnt_a, gnt_b, gnt_any;
  logic          last_gnt_q, last_gnt_d;
  logic          en_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] di_q;
  tag_t          tag1_q, tag2_q;

  rr_arb2 u_rr_arb2 (
    .a_req_i    (bus.a_valid),
    .b_req_i    (bus.b_valid),
    .last_gnt_i (last_gnt_q),
    .gnt_a_o    (rr_a),
    .gnt_b_o    (rr_b)
  );

`ifdef ARB_LOCK_EN
  arb_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_last;

  assign cnt_last = (32'(cnt_q) + 32'd1) >= MAX_LOCK;

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFree: begin
        gnt_a = rr_a;
        gnt_b = rr_b;
        // A one-beat lock limit never leaves the free state
        if (rr_a && bus.a_lock && MAX_LOCK > 1) begin
          state_d = StOwnA;
          cnt_d   = 8'd1;
        end else if (rr_b && bus.b_lock && MAX_LOCK > 1) begin
          state_d = StOwnB;
          cnt_d   = 8'd1;
        end
      end
      StOwnA: begin
        gnt_a = bus.a_valid;
        if (!bus.a_valid || !bus.a_lock || cnt_last) begin
          state_d = StFree;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StOwnB: begin
        gnt_b = bus.b_valid;
        if (!bus.b_valid || !bus.b_lock || cnt_last) begin
          state_d = StFree;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StFree;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_p or posedge rst_top) begin
    if (rst_top) begin
      state_q <= StFree;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    gnt_a = rr_a;
    gnt_b = rr_b;
  end
`endif

  assign gnt_any = gnt_a | gnt_b;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_b) begin
      last_gnt_d = 1'b1;
    end else if (gnt_a) begin
      last_gnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_p or posedge rst_top) begin
    if (rst_top) begin
      last_gnt_q <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      di_q       <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      en_q       <= gnt_any;
      we_q       <= gnt_any & (gnt_b ? bus.b_we : bus.a_we);
      if (gnt_any) begin
        addr_q <= gnt_b ? bus.b_addr : bus.a_addr;
        di_q   <= gnt_b ? bus.b_wdata : bus.a_wdata;
        tag1_q <= '{port: gnt_b, is_read: !(gnt_b ? bus.b_we : bus.a_we)};
      end
      // Only an enabled read beat yields a response
      tag2_q <= '{port: tag1_q.port, is_read: en_q & tag1_q.is_read};
    end
  end

  assign bus.a_ready  = gnt_a & ~rst_top;
  assign bus.b_ready  = gnt_b & ~rst_top;
  assign bus.ram_en   = en_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_di   = di_q;
  assign bus.a_rvalid = tag2_q.is_read & ~tag2_q.port;
  assign bus.b_rvalid = tag2_q.is_read & tag2_q.port;
  assign bus.a_rdata  = bus.ram_do;
  assign bus.b_rdata  = bus.ram_do;

endmodule

// File: tb/tb_jtag_ram_arbiter.sv
// Directed self-checking bench for jtag_ram_arbiter with a behavioural 512x32 RAM.
// Define ARB_LOCK_EN to add the lock-burst sequence (MAX_LOCK = 4).
module tb_jtag_ram_arbiter;

  logic clk_p = 1'b0;
  logic rst_top;
  int   errors = 0;
  int   checks = 0;
  int   acc;

  logic [31:0] mem [512];

  jtag_ram_arbiter_if #(.AW(9), .DW(32)) bus ();

  jtag_ram_arbiter #(
    .AW(9),
    .DW(32)
`ifdef ARB_LOCK_EN
    ,
    .MAX_LOCK(4)
`endif
  ) dut (
    .clk_p   (clk_p),
    .rst_top (rst_top),
    .bus     (bus)
  );

  always #5 clk_p = ~clk_p;

  // RAM model: reset refills a known pattern, read data appears one edge after enable
  always @(posedge clk_p) begin
    if (rst_top) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
      bus.ram_do <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_we    = 1'b0;
    bus.b_we    = 1'b0;
`ifdef ARB_LOCK_EN
    bus.a_lock  = 1'b0;
    bus.b_lock  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst_top = 1'b1;
    tick();
    rst_top = 1'b0;
  endtask

  initial begin
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.a_wdata = '0;
    bus.b_wdata = '0;
    idle();

    // Reset state, with requests pending
    rst_top     = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    tick();
    tick();
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_di", bus.ram_di, 32'd0);
    chk("rst_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    idle();
    rst_top = 1'b0;

    // B write then read of 0x005
    bus.b_valid = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 9'h005;
    bus.b_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_b_ready_wr", 32'(bus.b_ready), 32'd1);
    chk("t1_a_ready_wr", 32'(bus.a_ready), 32'd0);
    tick();
    chk("t1_en_wr", 32'(bus.ram_en), 32'd1);
    chk("t1_we_wr", 32'(bus.ram_we), 32'd1);
    chk("t1_addr_wr", 32'(bus.ram_addr), 32'h005);
    chk("t1_di_wr", bus.ram_di, 32'hDEAD_BEEF);
    bus.b_we = 1'b0;
    #1;
    chk("t1_b_ready_rd", 32'(bus.b_ready), 32'd1);
    tick();
    chk("t1_en_rd", 32'(bus.ram_en), 32'd1);
    chk("t1_we_rd", 32'(bus.ram_we), 32'd0);
    chk("t1_no_wr_resp", 32'(bus.b_rvalid), 32'd0);
    idle();
    tick();
    chk("t1_b_rvalid", 32'(bus.b_rvalid), 32'd1);
    chk("t1_b_rdata", bus.b_rdata, 32'hDEAD_BEEF);
    chk("t1_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("t1_en_idle", 32'(bus.ram_en), 32'd0);
    tick();
    chk("t1_b_rvalid_end", 32'(bus.b_rvalid), 32'd0);

    // Contending reads alternate B,A,B,A after reset
    do_reset();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_addr  = 9'h010;
    bus.b_addr  = 9'h020;
    for (int i = 0; i < 10; i++) begin
      if (i >= 8) idle();
      if (i >= 2) begin
        chk("t2_a_rvalid", 32'(bus.a_rvalid), 32'((i - 2) % 2 == 1));
        chk("t2_b_rvalid", 32'(bus.b_rvalid), 32'((i - 2) % 2 == 0));
        chk("t2_rdata", bus.a_rdata, ((i - 2) % 2 == 0) ? 32'hA5A5_0020 : 32'hA5A5_0010);
      end
      if (i < 8) begin
        #1;
        chk("t2_a_ready", 32'(bus.a_ready), 32'(i % 2 == 1));
        chk("t2_b_ready", 32'(bus.b_ready), 32'(i % 2 == 0));
      end
      tick();
    end
    chk("t2_drained", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);

    // A write then read of the top address, back to back
    bus.a_valid = 1'b1;
    bus.a_we    = 1'b1;
    bus.a_addr  = 9'h1FF;
    bus.a_wdata = 32'h1234_5678;
    #1;
    chk("t3_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    chk("t3_addr_wr", 32'(bus.ram_addr), 32'h1FF);
    chk("t3_we_wr", 32'(bus.ram_we), 32'd1);
    bus.a_we = 1'b0;
    tick();
    chk("t3_we_rd", 32'(bus.ram_we), 32'd0);
    chk("t3_addr_rd", 32'(bus.ram_addr), 32'h1FF);
    idle();
    tick();
    chk("t3_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t3_a_rdata", bus.a_rdata, 32'h1234_5678);
    chk("t3_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    tick();

    // Reset in the cycle after a read accept
    bus.a_valid = 1'b1;
    bus.a_addr  = 9'h033;
    tick();
    chk("t5_en_before", 32'(bus.ram_en), 32'd1);
    rst_top = 1'b1;
    #1;
    chk("t5_en_flushed", 32'(bus.ram_en), 32'd0);
    chk("t5_a_ready_rst", 32'(bus.a_ready), 32'd0);
    idle();
    tick();
    rst_top = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
      tick();
    end

    // A streaming alone for 20 cycles
    acc = 0;
    bus.a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.a_addr = 9'(i);
      #1;
      chk("t6_a_ready", 32'(bus.a_ready), 32'd1);
      tick();
      if (bus.ram_en) acc++;
    end
    idle();
    chk("t6_accesses", 32'(acc), 32'd20);
    tick();
    chk("t6_last_rdata", bus.a_rdata, 32'hA5A5_0013);
    tick();

`ifdef ARB_LOCK_EN
    // Lock burst: B wins the first tie, then A owns four beats, B one, A four
    do_reset();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_lock  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_a_ready", 32'(bus.a_ready), 32'(i % 5 != 0));
      chk("t4_b_ready", 32'(bus.b_ready), 32'(i % 5 == 0));
      tick();
    end
    idle();
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
